decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port IF_VALID  input  1  INSTRUCTION/PC_IN hold a valid fetched instruction.
REQ-006 SHALL have port INSTRUCTION  input  32  RV32I instruction word.
REQ-007 SHALL have port PC_IN  input  DATA_WIDTH  address of INSTRUCTION.
REQ-008 SHALL have ports READ_ADDRESS_1, READ_ADDRESS_2  output  ADDRESS_WIDTH  register-file read indices.
REQ-009 SHALL have ports READ_DATA_1, READ_DATA_2  input  DATA_WIDTH  register-file read data.
REQ-010 SHALL have ports WB_REGWRITE (1), WB_ADDRESS (ADDRESS_WIDTH), WB_DATA (DATA_WIDTH)  input  writeback-stage write in progress this cycle.
REQ-011 SHALL have port EX_READY  input  1  execute stage accepts a new entry this cycle.
REQ-012 SHALL have port FLUSH  input  1  taken branch/jump resolved; kill decode and ID/EX contents.
REQ-013 SHALL have port STALL_IF  output  1  fetch must hold IF_VALID/INSTRUCTION/PC_IN.
REQ-014 SHALL have registered outputs EX_VALID (1), EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM (DATA_WIDTH), EX_RS1, EX_RS2, EX_RD (ADDRESS_WIDTH), EX_OPCODE (7), EX_FUNCT3 (3), EX_FUNCT7B5 (1), EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_ILLEGAL (1 each).

Function
REQ-015 SHALL drive READ_ADDRESS_1 = INSTRUCTION[19:15], READ_ADDRESS_2 = INSTRUCTION[24:20] combinationally.
REQ-016 SHALL bypass: operand = WB_DATA when WB_REGWRITE=1, WB_ADDRESS!=0 and WB_ADDRESS equals that source index; else READ_DATA_n; source index 0 always yields 0.
REQ-017 SHALL generate sign-extended immediates: I (LOAD 0000011, OP-IMM 0010011, JALR 1100111), S (0100011), B (1100011, bit0=0), U (LUI 0110111, AUIPC 0010111, low 12 bits 0), J (JAL 1101111, bit0=0); R-type (0110011) immediate 0.
REQ-018 SHALL set REGWRITE for R, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR; MEMREAD only for LOAD; MEMWRITE only for STORE; any other opcode sets ILLEGAL=1 with all three controls 0.
REQ-019 SHALL treat rs1 as used for all legal opcodes except LUI, AUIPC, JAL; rs2 as used only for R, STORE, BRANCH.
REQ-020 SHALL flag load-use hazard = IF_VALID & EX_VALID & EX_MEMREAD & EX_RD!=0 & (EX_RD matches a used rs1 or rs2).
REQ-021 SHALL drive STALL_IF = IF_VALID & !FLUSH & (hazard | !EX_READY), combinationally.
REQ-022 SHALL, on a clock edge with FLUSH=1, clear EX_VALID, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE, EX_ILLEGAL regardless of EX_READY (FLUSH highest priority).
REQ-023 SHALL, with FLUSH=0 and EX_READY=0, hold every EX_* output unchanged.
REQ-024 SHALL, with FLUSH=0, EX_READY=1 and hazard=1, load a bubble: EX_VALID=0 and all control bits 0; datapath fields don't-care.
REQ-025 SHALL, with FLUSH=0, EX_READY=1, hazard=0, load decoded instruction: EX_VALID=IF_VALID, control bits gated by IF_VALID, one-cycle latency decode->EX.
REQ-026 SHALL re-evaluate bypass and register reads every cycle while stalled, so an operand written back during the stall is captured when the entry advances.

Reset
REQ-027 SHALL, while reset=0, asynchronously force EX_VALID, all EX_* data, index, control and ILLEGAL outputs to 0.
REQ-028 SHALL discard any in-flight entry on reset assertion mid-operation; first entry after deassertion is the instruction presented on the first edge with reset=1.
REQ-029 SHALL produce STALL_IF=0 while reset=0 and EX_VALID=0 (no hazard possible).

Verification
REQ-030 SHALL cover ADDI x5,x0,-1 (0xFFF00293), EX_READY=1 -> next cycle EX_VALID=1, EX_RD=5, EX_IMM=0xFFFFFFFF, EX_REGWRITE=1.
REQ-031 SHALL cover LW x6,0(x1) then ADD x7,x6,x2 -> STALL_IF=1 one cycle, bubble (EX_VALID=0), then ADD enters EX with EX_RS1=6.
REQ-032 SHALL cover WB_REGWRITE=1, WB_ADDRESS=2, WB_DATA=0x1234, READ_DATA_2=0 on ADD x7,x1,x2 -> EX_RS2_DATA=0x1234; same with WB_ADDRESS=0 -> 0.
REQ-033 SHALL cover EX_READY=0 for 3 cycles with new instruction at input -> EX_* unchanged, STALL_IF=1; FLUSH=1 during hold -> EX_VALID=0 next edge.
REQ-034 SHALL cover opcode 0x7F -> EX_ILLEGAL=1, EX_REGWRITE/MEMREAD/MEMWRITE=0; reset=0 mid-stream -> all EX_* 0 immediately, without clock.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: register read with writeback bypass, immediate generation,
// control decode, load-use hazard detection and the registered ID/EX entry.
module decode_stage #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     IF_VALID,
  input  logic [31:0]              INSTRUCTION,
  input  logic [DATA_WIDTH-1:0]    PC_IN,
  output logic [ADDRESS_WIDTH-1:0] READ_ADDRESS_1,
  output logic [ADDRESS_WIDTH-1:0] READ_ADDRESS_2,
  input  logic [DATA_WIDTH-1:0]    READ_DATA_1,
  input  logic [DATA_WIDTH-1:0]    READ_DATA_2,
  input  logic                     WB_REGWRITE,
  input  logic [ADDRESS_WIDTH-1:0] WB_ADDRESS,
  input  logic [DATA_WIDTH-1:0]    WB_DATA,
  input  logic                     EX_READY,
  input  logic                     FLUSH,
  output logic                     STALL_IF,
  output logic                     EX_VALID,
  output logic [DATA_WIDTH-1:0]    EX_PC,
  output logic [DATA_WIDTH-1:0]    EX_RS1_DATA,
  output logic [DATA_WIDTH-1:0]    EX_RS2_DATA,
  output logic [DATA_WIDTH-1:0]    EX_IMM,
  output logic [ADDRESS_WIDTH-1:0] EX_RS1,
  output logic [ADDRESS_WIDTH-1:0] EX_RS2,
  output logic [ADDRESS_WIDTH-1:0] EX_RD,
  output logic [6:0]               EX_OPCODE,
  output logic [2:0]               EX_FUNCT3,
  output logic                     EX_FUNCT7B5,
  output logic                     EX_REGWRITE,
  output logic                     EX_MEMREAD,
  output logic                     EX_MEMWRITE,
  output logic                     EX_ILLEGAL
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [6:0]               opcode;
  logic [ADDRESS_WIDTH-1:0] rs1, rs2, rd;
  logic signed [31:0]       imm;
  logic                     regwrite, memread, memwrite, illegal, use_rs1, use_rs2;
  logic [DATA_WIDTH-1:0]    rs1_data, rs2_data;
  logic                     hazard, load_ok;

  logic                     ex_valid_q, ex_funct7b5_q;
  logic                     ex_regwrite_q, ex_memread_q, ex_memwrite_q, ex_illegal_q;
  logic [DATA_WIDTH-1:0]    ex_pc_q, ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic [ADDRESS_WIDTH-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic [6:0]               ex_opcode_q;
  logic [2:0]               ex_funct3_q;

  assign opcode         = INSTRUCTION[6:0];
  assign rs1            = ADDRESS_WIDTH'(INSTRUCTION[19:15]);
  assign rs2            = ADDRESS_WIDTH'(INSTRUCTION[24:20]);
  assign rd             = ADDRESS_WIDTH'(INSTRUCTION[11:7]);
  assign READ_ADDRESS_1 = rs1;
  assign READ_ADDRESS_2 = rs2;

  always_comb begin
    imm      = '0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    illegal  = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OpLoad, OpImm, OpJalr: begin
        imm      = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]};
        regwrite = 1'b1;
        memread  = (opcode == OpLoad);
        use_rs1  = 1'b1;
      end
      OpStore: begin
        imm      = {{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
        memwrite = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OpBranch: begin
        imm     = {{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                   INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OpLui, OpAuipc: begin
        imm      = {INSTRUCTION[31:12], 12'b0};
        regwrite = 1'b1;
      end
      OpJal: begin
        imm      = {{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                    INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
        regwrite = 1'b1;
      end
      OpReg: begin
        regwrite = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // x0 reads as zero; otherwise a same-cycle writeback overrides the register file.
  always_comb begin
    rs1_data = READ_DATA_1;
    rs2_data = READ_DATA_2;
    if (rs1 == '0) rs1_data = '0;
    else if (WB_REGWRITE && WB_ADDRESS == rs1) rs1_data = WB_DATA;
    if (rs2 == '0) rs2_data = '0;
    else if (WB_REGWRITE && WB_ADDRESS == rs2) rs2_data = WB_DATA;
  end

  assign hazard   = IF_VALID & ex_valid_q & ex_memread_q & (ex_rd_q != '0) &
                    ((use_rs1 & (ex_rd_q == rs1)) | (use_rs2 & (ex_rd_q == rs2)));
  assign load_ok  = IF_VALID & ~hazard;
  assign STALL_IF = reset & IF_VALID & ~FLUSH & (hazard | ~EX_READY);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
    end else if (FLUSH) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
    end else if (EX_READY) begin
      ex_valid_q    <= load_ok;
      ex_regwrite_q <= load_ok & regwrite;
      ex_memread_q  <= load_ok & memread;
      ex_memwrite_q <= load_ok & memwrite;
      ex_illegal_q  <= load_ok & illegal;
      ex_pc_q       <= PC_IN;
      ex_rs1_data_q <= rs1_data;
      ex_rs2_data_q <= rs2_data;
      ex_imm_q      <= DATA_WIDTH'(imm);
      ex_rs1_q      <= rs1;
      ex_rs2_q      <= rs2;
      ex_rd_q       <= rd;
      ex_opcode_q   <= opcode;
      ex_funct3_q   <= INSTRUCTION[14:12];
      ex_funct7b5_q <= INSTRUCTION[30];
    end
  end

  assign EX_VALID    = ex_valid_q;
  assign EX_PC       = ex_pc_q;
  assign EX_RS1_DATA = ex_rs1_data_q;
  assign EX_RS2_DATA = ex_rs2_data_q;
  assign EX_IMM      = ex_imm_q;
  assign EX_RS1      = ex_rs1_q;
  assign EX_RS2      = ex_rs2_q;
  assign EX_RD       = ex_rd_q;
  assign EX_OPCODE   = ex_opcode_q;
  assign EX_FUNCT3   = ex_funct3_q;
  assign EX_FUNCT7B5 = ex_funct7b5_q;
  assign EX_REGWRITE = ex_regwrite_q;
  assign EX_MEMREAD  = ex_memread_q;
  assign EX_MEMWRITE = ex_memwrite_q;
  assign EX_ILLEGAL  = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an instruction-level model of the ID/EX entry is
// compared against the DUT after every edge, plus literal expectations at key points.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        IF_VALID, WB_REGWRITE, EX_READY, FLUSH;
  logic [31:0] INSTRUCTION, PC_IN, WB_DATA;
  logic [4:0]  WB_ADDRESS;
  logic [4:0]  READ_ADDRESS_1, READ_ADDRESS_2;
  logic [31:0] READ_DATA_1, READ_DATA_2;
  logic        STALL_IF, EX_VALID, EX_FUNCT7B5, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE;
  logic        EX_ILLEGAL;
  logic [31:0] EX_PC, EX_RS1_DATA, EX_RS2_DATA, EX_IMM;
  logic [4:0]  EX_RS1, EX_RS2, EX_RD;
  logic [6:0]  EX_OPCODE;
  logic [2:0]  EX_FUNCT3;

  logic [31:0] rf [32];
  assign READ_DATA_1 = rf[INSTRUCTION[19:15]];
  assign READ_DATA_2 = rf[INSTRUCTION[24:20]];

  always #5 clock = ~clock;

  decode_stage #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .IF_VALID(IF_VALID), .INSTRUCTION(INSTRUCTION),
    .PC_IN(PC_IN), .READ_ADDRESS_1(READ_ADDRESS_1), .READ_ADDRESS_2(READ_ADDRESS_2),
    .READ_DATA_1(READ_DATA_1), .READ_DATA_2(READ_DATA_2), .WB_REGWRITE(WB_REGWRITE),
    .WB_ADDRESS(WB_ADDRESS), .WB_DATA(WB_DATA), .EX_READY(EX_READY), .FLUSH(FLUSH),
    .STALL_IF(STALL_IF), .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_RS1_DATA(EX_RS1_DATA),
    .EX_RS2_DATA(EX_RS2_DATA), .EX_IMM(EX_IMM), .EX_RS1(EX_RS1), .EX_RS2(EX_RS2),
    .EX_RD(EX_RD), .EX_OPCODE(EX_OPCODE), .EX_FUNCT3(EX_FUNCT3),
    .EX_FUNCT7B5(EX_FUNCT7B5), .EX_REGWRITE(EX_REGWRITE), .EX_MEMREAD(EX_MEMREAD),
    .EX_MEMWRITE(EX_MEMWRITE), .EX_ILLEGAL(EX_ILLEGAL)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7, rw, mr, mw, ill;
  } ex_t;

  ex_t  m;
  int   checks = 0;
  int   errors = 0;
  logic last_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction-format rules expressed as signed arithmetic on the fields.
  function automatic void classify(input logic [31:0] ins, output logic [31:0] imm,
                                   output logic rw, mr, mw, ill, u1, u2);
    int s, hi;
    s  = ins;
    hi = s >>> 31;
    imm = 0; rw = 0; mr = 0; mw = 0; ill = 0; u1 = 0; u2 = 0;
    case (ins[6:0])
      7'h03:        begin imm = s >>> 20; rw = 1; mr = 1; u1 = 1; end
      7'h13, 7'h67: begin imm = s >>> 20; rw = 1; u1 = 1; end
      7'h23: begin
        imm = (s >>> 25) * 32 + int'(ins[11:7]); mw = 1; u1 = 1; u2 = 1;
      end
      7'h63: begin
        imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        u1 = 1; u2 = 1;
      end
      7'h37, 7'h17: begin imm = ins & 32'hFFFF_F000; rw = 1; end
      7'h6F: begin
        imm = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
            + int'(ins[30:21]) * 2;
        rw = 1;
      end
      7'h33:   begin rw = 1; u1 = 1; u2 = 1; end
      default: ill = 1;
    endcase
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] idx);
    if (idx == 0) return 0;
    if (WB_REGWRITE && WB_ADDRESS == idx) return WB_DATA;
    return rf[idx];
  endfunction

  task automatic compare_all();
    chk("EX_VALID", 32'(EX_VALID), 32'(m.v));
    chk("EX_REGWRITE", 32'(EX_REGWRITE), 32'(m.rw));
    chk("EX_MEMREAD", 32'(EX_MEMREAD), 32'(m.mr));
    chk("EX_MEMWRITE", 32'(EX_MEMWRITE), 32'(m.mw));
    chk("EX_ILLEGAL", 32'(EX_ILLEGAL), 32'(m.ill));
    if (m.v || !reset) begin
      chk("EX_PC", EX_PC, m.pc);
      chk("EX_RS1_DATA", EX_RS1_DATA, m.d1);
      chk("EX_RS2_DATA", EX_RS2_DATA, m.d2);
      chk("EX_IMM", EX_IMM, m.imm);
      chk("EX_RS1", 32'(EX_RS1), 32'(m.rs1));
      chk("EX_RS2", 32'(EX_RS2), 32'(m.rs2));
      chk("EX_RD", 32'(EX_RD), 32'(m.rd));
      chk("EX_OPCODE", 32'(EX_OPCODE), 32'(m.opc));
      chk("EX_FUNCT3", 32'(EX_FUNCT3), 32'(m.f3));
      chk("EX_FUNCT7B5", 32'(EX_FUNCT7B5), 32'(m.f7));
    end
  endtask

  // One clock: check combinational outputs, predict the next entry, compare after the edge.
  task automatic tick();
    logic [31:0] imm;
    logic rw, mr, mw, ill, u1, u2, hz, stall;
    ex_t nx;
    #1;
    classify(INSTRUCTION, imm, rw, mr, mw, ill, u1, u2);
    hz = IF_VALID && m.v && m.mr && m.rd != 0 &&
         ((u1 && m.rd == INSTRUCTION[19:15]) || (u2 && m.rd == INSTRUCTION[24:20]));
    stall = reset && IF_VALID && !FLUSH && (hz || !EX_READY);
    chk("STALL_IF", 32'(STALL_IF), 32'(stall));
    chk("READ_ADDRESS_1", 32'(READ_ADDRESS_1), 32'(INSTRUCTION[19:15]));
    chk("READ_ADDRESS_2", 32'(READ_ADDRESS_2), 32'(INSTRUCTION[24:20]));
    last_stall = STALL_IF;
    nx = m;
    if (!reset) nx = '0;
    else if (FLUSH) begin
      nx.v = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0; nx.ill = 0;
    end else if (EX_READY) begin
      nx.v   = IF_VALID && !hz;
      nx.rw  = nx.v && rw;
      nx.mr  = nx.v && mr;
      nx.mw  = nx.v && mw;
      nx.ill = nx.v && ill;
      nx.pc  = PC_IN;
      nx.d1  = opnd(INSTRUCTION[19:15]);
      nx.d2  = opnd(INSTRUCTION[24:20]);
      nx.imm = imm;
      nx.rs1 = INSTRUCTION[19:15];
      nx.rs2 = INSTRUCTION[24:20];
      nx.rd  = INSTRUCTION[11:7];
      nx.opc = INSTRUCTION[6:0];
      nx.f3  = INSTRUCTION[14:12];
      nx.f7  = INSTRUCTION[30];
    end
    @(posedge clock);
    m = nx;
    if (WB_REGWRITE && WB_ADDRESS != 0) rf[WB_ADDRESS] = WB_DATA;
    #1;
    compare_all();
  endtask

  task automatic drv(input logic [31:0] ins, input logic [31:0] pc);
    IF_VALID = 1; INSTRUCTION = ins; PC_IN = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i * 32'h111;
    rf[0] = 32'hDEAD_BEEF;
    rf[2] = 32'h0;
    reset = 0; IF_VALID = 0; INSTRUCTION = 32'h0000_0013; PC_IN = 0;
    WB_REGWRITE = 0; WB_ADDRESS = 0; WB_DATA = 0; EX_READY = 1; FLUSH = 0;
    m = '0;
    #2;
    compare_all();
    chk("reset STALL_IF", 32'(STALL_IF), 32'h0);
    @(negedge clock);
    reset = 1;

    // ADDI x5,x0,-1
    drv(32'hFFF0_0293, 32'h100); tick();
    chk("addi EX_VALID", 32'(EX_VALID), 32'h1);
    chk("addi EX_RD", 32'(EX_RD), 32'h5);
    chk("addi EX_IMM", EX_IMM, 32'hFFFF_FFFF);
    chk("addi EX_REGWRITE", 32'(EX_REGWRITE), 32'h1);
    // SUB, SW, BEQ, LUI, AUIPC, JAL, JALR
    drv(32'h4020_81B3, 32'h104); tick();
    drv(32'h0020_A423, 32'h108); tick();
    chk("sw EX_IMM", EX_IMM, 32'h8);
    drv(32'hFE20_8EE3, 32'h10C); tick();
    chk("beq EX_IMM", EX_IMM, 32'hFFFF_FFFC);
    drv(32'h1234_5237, 32'h110); tick();
    chk("lui EX_IMM", EX_IMM, 32'h1234_5000);
    drv(32'h0000_1217, 32'h114); tick();
    drv(32'h0080_00EF, 32'h118); tick();
    chk("jal EX_IMM", EX_IMM, 32'h8);
    drv(32'h0000_8067, 32'h11C); tick();

    // LW x6,0(x1) then ADD x7,x6,x2: one stall, bubble, then ADD.
    drv(32'h0000_A303, 32'h120); tick();
    chk("lw EX_MEMREAD", 32'(EX_MEMREAD), 32'h1);
    drv(32'h0023_03B3, 32'h124); tick();
    chk("loaduse STALL_IF", 32'(last_stall), 32'h1);
    chk("loaduse bubble", 32'(EX_VALID), 32'h0);
    tick();
    chk("loaduse STALL_IF released", 32'(last_stall), 32'h0);
    chk("add EX_RS1", 32'(EX_RS1), 32'h6);
    chk("add EX_VALID", 32'(EX_VALID), 32'h1);

    // Writeback bypass into ADD x7,x1,x2.
    WB_REGWRITE = 1; WB_ADDRESS = 2; WB_DATA = 32'h1234;
    drv(32'h0020_83B3, 32'h128); tick();
    chk("bypass rs2", EX_RS2_DATA, 32'h1234);
    rf[2] = 0;
    WB_ADDRESS = 0; tick();
    chk("bypass x0", EX_RS2_DATA, 32'h0);
    WB_REGWRITE = 0;

    // Hold for 3 cycles with x1 written back during the stall, then flush and resume.
    EX_READY = 0;
    drv(32'h0010_8393, 32'h12C);
    tick(); tick();
    WB_REGWRITE = 1; WB_ADDRESS = 1; WB_DATA = 32'hCAFE;
    tick();
    WB_REGWRITE = 0;
    chk("hold STALL_IF", 32'(last_stall), 32'h1);
    chk("hold EX_PC", EX_PC, 32'h128);
    FLUSH = 1; tick();
    chk("flush EX_VALID", 32'(EX_VALID), 32'h0);
    FLUSH = 0; EX_READY = 1; tick();
    chk("stall-wb rs1 data", EX_RS1_DATA, 32'hCAFE);
    chk("stall-wb imm", EX_IMM, 32'h1);

    // Illegal opcode, then no valid fetch.
    drv(32'h0000_007F, 32'h130); tick();
    chk("illegal EX_ILLEGAL", 32'(EX_ILLEGAL), 32'h1);
    chk("illegal EX_REGWRITE", 32'(EX_REGWRITE), 32'h0);
    IF_VALID = 0; tick();

    // Asynchronous reset mid-stream.
    drv(32'h0000_A303, 32'h134); tick();
    EX_READY = 0;
    reset = 0; m = '0;
    #1;
    chk("async EX_VALID", 32'(EX_VALID), 32'h0);
    chk("async EX_PC", EX_PC, 32'h0);
    chk("async EX_MEMREAD", 32'(EX_MEMREAD), 32'h0);
    compare_all();
    tick();
    EX_READY = 1;
    @(negedge clock);
    reset = 1;
    drv(32'hFFF0_0293, 32'h200); tick();
    chk("post-reset EX_PC", EX_PC, 32'h200);
    IF_VALID = 0; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
